lfo_scheduler: RTL and testbench

LFO_SCHEDULER -- requirements
Module: lfo_scheduler

---
 rtl/lfo_scheduler.sv | 178 +++++++++++++++++
 tb/tb_lfo_scheduler.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfo_scheduler.sv
// Four LFO channels share one 16-entry sine table. Each channel ticks on its own
// period; a round-robin arbiter issues at most one table sample per cycle.
module lfo_scheduler #(
    parameter int NCH = 4,
    parameter int PW  = 32
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_ch,
    input  logic [PW-1:0]     cfg_period,
    input  logic [NCH-1:0]    ch_en,
    input  logic [NCH-1:0]    ovr_clr,
    output logic              out_valid,
    output logic [1:0]        out_ch,
    output logic signed [7:0] out_sample,
    output logic [NCH*8-1:0]  ch_sample,
    output logic [NCH-1:0]    overrun
);

    logic [PW-1:0]     period_q [NCH];
    logic [PW-1:0]     period_d [NCH];
    logic [PW-1:0]     cnt_q    [NCH];
    logic [PW-1:0]     cnt_d    [NCH];
    logic [3:0]        phase_q  [NCH];
    logic [3:0]        phase_d  [NCH];
    logic signed [7:0] samp_q   [NCH];
    logic signed [7:0] samp_d   [NCH];
    logic [NCH-1:0]    pend_q, pend_d;
    logic [NCH-1:0]    ovr_q, ovr_d;
    logic [1:0]        last_q, last_d;
    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_ch_q, out_ch_d;
    logic signed [7:0] out_sample_q, out_sample_d;

    logic [NCH-1:0]    cfg_mask;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    gnt_one;
    logic              gnt_vld;
    logic [1:0]        gnt_ch;
    logic [1:0]        cand;

    function automatic logic signed [7:0] sine_lut(input logic [3:0] ph);
        logic signed [7:0] v;
        case (ph)
            4'd0:    v = 8'sd0;
            4'd1:    v = 8'sd6;
            4'd2:    v = 8'sd11;
            4'd3:    v = 8'sd15;
            4'd4:    v = 8'sd16;
            4'd5:    v = 8'sd15;
            4'd6:    v = 8'sd11;
            4'd7:    v = 8'sd6;
            4'd8:    v = 8'sd0;
            4'd9:    v = -8'sd6;
            4'd10:   v = -8'sd11;
            4'd11:   v = -8'sd15;
            4'd12:   v = -8'sd16;
            4'd13:   v = -8'sd15;
            4'd14:   v = -8'sd11;
            default: v = -8'sd6;
        endcase
        return v;
    endfunction

    // A channel being reconfigured, or disabled, is invisible to the arbiter.
    always_comb begin
        cfg_mask = '0;
        if (cfg_we) begin
            cfg_mask = NCH'(1) << cfg_ch;
        end
        req = pend_q & ch_en & ~cfg_mask;
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = last_q;
        cand    = last_q;
        for (int k = 0; k < NCH; k++) begin
            cand = last_q + 2'(k + 1);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_ch  = cand;
            end
        end
    end

    always_comb begin
        period_d = period_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        samp_d   = samp_q;
        pend_d   = pend_q;
        ovr_d    = ovr_q;
        tick     = '0;
        gnt_one  = '0;
        for (int i = 0; i < NCH; i++) begin
            gnt_one[i] = gnt_vld && (gnt_ch == 2'(i));
            tick[i]    = ch_en[i] && (cnt_q[i] >= period_q[i]);

            if (!ch_en[i]) begin
                cnt_d[i]  = '0;
                pend_d[i] = 1'b0;
            end else if (tick[i]) begin
                cnt_d[i]  = '0;
                pend_d[i] = 1'b1;
            end else begin
                cnt_d[i]  = cnt_q[i] + PW'(1);
                pend_d[i] = pend_q[i] && !gnt_one[i];
            end

            // A fresh missed tick beats a simultaneous clear.
            ovr_d[i] = (tick[i] && pend_q[i] && !gnt_one[i]) || (ovr_q[i] && !ovr_clr[i]);

            if (gnt_one[i]) begin
                phase_d[i] = phase_q[i] + 4'd1;
                samp_d[i]  = sine_lut(phase_q[i]);
            end

            if (cfg_mask[i]) begin
                period_d[i] = cfg_period;
                cnt_d[i]    = '0;
                phase_d[i]  = '0;
                pend_d[i]   = 1'b0;
                ovr_d[i]    = 1'b0;
            end
        end
    end

    always_comb begin
        out_valid_d  = gnt_vld;
        out_ch_d     = out_ch_q;
        out_sample_d = out_sample_q;
        last_d       = last_q;
        if (gnt_vld) begin
            out_ch_d     = gnt_ch;
            out_sample_d = sine_lut(phase_q[gnt_ch]);
            last_d       = gnt_ch;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            period_q     <= '{default: '1};
            cnt_q        <= '{default: '0};
            phase_q      <= '{default: '0};
            samp_q       <= '{default: '0};
            pend_q       <= '0;
            ovr_q        <= '0;
            last_q       <= 2'(NCH - 1);
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_sample_q <= '0;
        end else begin
            period_q     <= period_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            samp_q       <= samp_d;
            pend_q       <= pend_d;
            ovr_q        <= ovr_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            out_sample_q <= out_sample_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_sample = out_sample_q;
    assign overrun    = ovr_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch_sample
        assign ch_sample[gi*8 +: 8] = samp_q[gi];
    end

endmodule

// File: tb/tb_lfo_scheduler.sv
// Directed bench for lfo_scheduler: stimulus pushes expected samples with their
// arrival cycle; a negedge monitor pops and compares every out_valid strobe.
module tb_lfo_scheduler;

    localparam int NCH = 4;
    localparam int PW  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [PW-1:0]     cfg_period;
    logic [NCH-1:0]    ch_en;
    logic [NCH-1:0]    ovr_clr;
    logic              out_valid;
    logic [1:0]        out_ch;
    logic signed [7:0] out_sample;
    logic [NCH*8-1:0]  ch_sample;
    logic [NCH-1:0]    overrun;

    lfo_scheduler #(.NCH(NCH), .PW(PW)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .ch_en      (ch_en),
        .ovr_clr    (ovr_clr),
        .out_valid  (out_valid),
        .out_ch     (out_ch),
        .out_sample (out_sample),
        .ch_sample  (ch_sample),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ch;
        int smp;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tbl[16] = '{0, 6, 11, 15, 16, 15, 11, 6, 0, -6, -11, -15, -16, -15, -11, -6};

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic expect_smp(input int ch, input int smp, input int at);
        exp_q.push_back('{ch: ch, smp: smp, at: at});
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Monitor: anything still queued past its cycle was never emitted.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            check("missed_sample_cycle", cyc, exp_q[0].at);
            void'(exp_q.pop_front());
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got ch %0d sample %0d, expected no output (cycle %0d)",
                         out_ch, out_sample, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_ch", int'(out_ch), e.ch);
                check("out_sample", int'(out_sample), e.smp);
                check("out_cycle", cyc, e.at);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n   = 1'b0;
        cfg_we  = 1'b0;
        ch_en   = '0;
        ovr_clr = '0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sample", int'(out_sample), 0);
        check("rst_ch_sample", int'(ch_sample), 0);
        check("rst_overrun", int'(overrun), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic setup_all(input int p1, output int c);
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < NCH; i++) begin
            cfg_we     = 1'b1;
            cfg_ch     = 2'(i);
            cfg_period = (i == 1) ? PW'(p1) : '0;
            @(negedge clk);
        end
        cfg_we = 1'b0;
        ch_en  = 4'hF;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int r;
        cfg_we     = 1'b0;
        cfg_ch     = '0;
        cfg_period = '0;
        ch_en      = '0;
        ovr_clr    = '0;
        do_reset();

        // Single channel, period 3: one sample every 4 cycles, table wraps after 16.
        @(negedge clk);
        c = cyc;
        for (int j = 0; j < 17; j++) expect_smp(0, tbl[j % 16], c + 6 + 4 * j);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 3; ch_en = 4'b0001;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_cyc(c + 66);
        #1 check("ch0_last_sample", int'($signed(ch_sample[7:0])), -6);
        wait_cyc(c + 71);
        ch_en = '0;
        do_reset();

        // All channels period 0: strict rotation, every channel overruns.
        setup_all(0, c);
        for (int j = 0; j < 12; j++) expect_smp(j % 4, tbl[j / 4], c + 6 + j);
        wait_cyc(c + 5);
        #1 check("all0_overrun_early", int'(overrun), 0);
        wait_cyc(c + 8);
        #1 check("all0_overrun_set", int'(overrun), 15);
        wait_cyc(c + 17);
        ch_en = '0;
        #1 check("all0_ch_sample", int'(ch_sample), 32'h0B0B0B0B);
        do_reset();

        // Ch1 period 1: overrun, clear works alone, loses to a coincident event.
        setup_all(1, c);
        for (int j = 0; j < 12; j++) expect_smp(j % 4, tbl[j / 4], c + 6 + j);
        wait_cyc(c + 9);
        #1 check("p1_overrun_before_ch1", int'(overrun), 13);
        wait_cyc(c + 10);
        #1 check("p1_overrun_ch1_set", int'(overrun), 15);
        wait_cyc(c + 11);
        ovr_clr = 4'b0010;
        wait_cyc(c + 12);
        ovr_clr = '0;
        #1 check("p1_overrun_cleared", int'(overrun), 13);
        wait_cyc(c + 13);
        ovr_clr = 4'b0010;
        wait_cyc(c + 14);
        ovr_clr = '0;
        #1 check("p1_overrun_set_wins", int'(overrun), 15);
        wait_cyc(c + 17);
        ch_en = '0;
        do_reset();

        // Reconfigure ch2 in the cycle it would be granted: ch3 goes instead.
        setup_all(0, c);
        expect_smp(0, 0, c + 6);
        expect_smp(1, 0, c + 7);
        expect_smp(3, 0, c + 8);
        expect_smp(0, 6, c + 9);
        expect_smp(1, 6, c + 10);
        expect_smp(2, 0, c + 11);
        expect_smp(3, 6, c + 12);
        expect_smp(0, 11, c + 13);
        wait_cyc(c + 7);
        cfg_we = 1'b1; cfg_ch = 2'd2; cfg_period = 0;
        wait_cyc(c + 8);
        cfg_we = 1'b0;
        #1 check("cfg_ch2_overrun_cleared", int'(overrun), 11);
        wait_cyc(c + 13);
        ch_en = '0;
        do_reset();

        // Asynchronous reset pulse mid-stream, then restart with period 2.
        @(negedge clk);
        c = cyc;
        expect_smp(0, 0, c + 6);
        expect_smp(0, 6, c + 10);
        expect_smp(0, 11, c + 14);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 3; ch_en = 4'b0001;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_cyc(c + 14);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_out_sample", int'(out_sample), 0);
        check("async_rst_ch_sample", int'(ch_sample), 0);
        #8 rst_n = 1'b1;
        @(negedge clk);
        r = cyc;
        expect_smp(0, 0, r + 5);
        expect_smp(0, 6, r + 8);
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_period = 2;
        @(negedge clk);
        cfg_we = 1'b0;
        wait_cyc(r + 8);
        ch_en = '0;
        wait_cyc(r + 14);
        #1 check("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
